// File: rtl/dev_timer.sv
// dev_timer: memory-mapped down-counting timer on the Aquila device bus.
// Register map (byte offset, bits [7:0] of the address):
//   0x00 CTRL   bit0 EN, bit1 AUTO (reload on expiry), bit2 IE (irq enable)
//   0x04 LOAD   reload value; a write also copies the value into COUNT
//   0x08 COUNT  read-only current count
//   0x0C STATUS bit0 EXP, sticky, write-1-to-clear
//   0x10 PRESC  16-bit prescaler, only when DEV_TIMER_PRESCALE_EN is defined
// Define DEV_TIMER_PRESCALE_EN to add the PRESC register and the prescale
// counter that gates the COUNT decrement; without it 0x10 is unmapped.
module dev_timer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int AXI_LATENCY        = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            M_DEVICE_strobe,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_DEVICE_addr,
    input  logic                            M_DEVICE_rw,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] M_DEVICE_byte_enable,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_DEVICE_core2dev_data,
    output logic                            M_DEVICE_data_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_DEVICE_dev2core_data,
    output logic                            irq
);

    localparam int              DW       = C_M_AXI_DATA_WIDTH;
    localparam logic [7:0]      LAT      = 8'(AXI_LATENCY);
    localparam logic [7:0]      A_CTRL   = 8'h00;
    localparam logic [7:0]      A_LOAD   = 8'h04;
    localparam logic [7:0]      A_COUNT  = 8'h08;
    localparam logic [7:0]      A_STAT   = 8'h0C;
    localparam logic [DW-1:0]   ONE      = DW'(1);
    localparam logic [DW-1:0]   UNMAPPED = DW'(32'hdeadbeef);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    // Bus handshake state
    state_t        state_q;
    logic [7:0]    lat_q;
    logic [7:0]    addr_q;
    logic          wr_q;
    logic [DW-1:0] wdata_q;
    logic          ready_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rd_mux;

    // Timer registers
    logic          en_q, en_d;
    logic          auto_q, auto_d;
    logic          ie_q, ie_d;
    logic [DW-1:0] load_q, load_d;
    logic [DW-1:0] count_q, count_d;
    logic          exp_q, exp_d;
    logic          irq_q, irq_d;

    // Register-write strobes and counting qualifiers
    logic commit;
    logic ctrl_wr;
    logic load_wr;
    logic stat_wr;
    logic psc_hit;
    logic tick;
    logic expire;

    // Address bits above [7:0] and byte enables do not take part in decode.
    logic unused_bus;
    assign unused_bus = ^{M_DEVICE_byte_enable, M_DEVICE_addr[C_M_AXI_ADDR_WIDTH-1:8]};

    // A write takes effect once, on the edge that leaves DONE.
    assign commit  = (state_q == DONE) && wr_q;
    assign ctrl_wr = commit && (addr_q == A_CTRL);
    assign load_wr = commit && (addr_q == A_LOAD);
    assign stat_wr = commit && (addr_q == A_STAT);

`ifdef DEV_TIMER_PRESCALE_EN
    localparam logic [7:0] A_PRESC = 8'h10;

    logic [15:0] presc_q, presc_d;
    logic [15:0] psc_q, psc_d;
    logic        presc_wr;

    assign presc_wr = commit && (addr_q == A_PRESC);
    assign psc_hit  = (psc_q == presc_q);

    // Prescale counter: restarts on LOAD writes and while disabled, wraps on a hit.
    always_comb begin
        presc_d = presc_wr ? wdata_q[15:0] : presc_q;
        psc_d   = psc_q + 16'd1;
        if (!en_q || load_wr || psc_hit) begin
            psc_d = '0;
        end
    end

    // Prescaler registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            psc_q   <= '0;
        end else begin
            presc_q <= presc_d;
            psc_q   <= psc_d;
        end
    end
`else
    assign psc_hit = 1'b1;
`endif

    // Read decode of the addressed register.
    always_comb begin
        rd_mux = UNMAPPED;
        case (addr_q)
            A_CTRL:  rd_mux = {{(DW-3){1'b0}}, ie_q, auto_q, en_q};
            A_LOAD:  rd_mux = load_q;
            A_COUNT: rd_mux = count_q;
            A_STAT:  rd_mux = {{(DW-1){1'b0}}, exp_q};
`ifdef DEV_TIMER_PRESCALE_EN
            A_PRESC: rd_mux = {{(DW-16){1'b0}}, presc_q};
`endif
            default: rd_mux = UNMAPPED;
        endcase
    end

    // Bus FSM: IDLE -> READ/WRITE for AXI_LATENCY+1 cycles -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    lat_q   <= '0;
                    if (M_DEVICE_strobe) begin
                        addr_q  <= M_DEVICE_addr[7:0];
                        wr_q    <= M_DEVICE_rw;
                        wdata_q <= M_DEVICE_core2dev_data;
                        state_q <= M_DEVICE_rw ? WRITE : READ;
                    end
                end
                READ: begin
                    rdata_q <= rd_mux;
                    if (lat_q == LAT) begin
                        state_q <= DONE;
                    end else begin
                        lat_q <= lat_q + 8'd1;
                    end
                end
                WRITE: begin
                    if (lat_q == LAT) begin
                        state_q <= DONE;
                    end else begin
                        lat_q <= lat_q + 8'd1;
                    end
                end
                DONE: begin
                    lat_q   <= '0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Timer next state: decrement/expiry first, then bus writes override.
    // A LOAD write beats a same-edge expiry; an expiry beats a same-edge W1C.
    always_comb begin
        tick    = en_q && (count_q != '0) && psc_hit;
        expire  = tick && (count_q == ONE) && !load_wr;
        en_d    = en_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;
        if (ctrl_wr) begin
            {ie_d, auto_d, en_d} = wdata_q[2:0];
        end
        if (tick) begin
            if (count_q == ONE) begin
                count_d = auto_q ? load_q : '0;
            end else begin
                count_d = count_q - ONE;
            end
        end
        if (load_wr) begin
            load_d  = wdata_q;
            count_d = wdata_q;
        end
        if (stat_wr && wdata_q[0]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end
        irq_d = exp_q && ie_q;
    end

    // Timer registers and the registered interrupt level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            en_q    <= en_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            irq_q   <= irq_d;
        end
    end

    assign M_DEVICE_data_ready    = ready_q;
    assign M_DEVICE_dev2core_data = rdata_q;
    assign irq                    = irq_q;

endmodule

// File: tb/tb_dev_timer.sv
// Self-checking bench for dev_timer: register table, timer timing sequences,
// bus-versus-timer collisions and reset during an access.
module tb_dev_timer;

    localparam int LAT = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
`ifdef DEV_TIMER_PRESCALE_EN
    localparam logic [31:0] OFF10_RST = 32'h0;
`else
    localparam logic [31:0] OFF10_RST = 32'hdeadbeef;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          strobe;
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW/8-1:0] be;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          irq;

    dev_timer #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .AXI_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .M_DEVICE_strobe(strobe),
        .M_DEVICE_addr(addr),
        .M_DEVICE_rw(rw),
        .M_DEVICE_byte_enable(be),
        .M_DEVICE_core2dev_data(wdata),
        .M_DEVICE_data_ready(ready),
        .M_DEVICE_dev2core_data(rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Edge index: value after posedge N is N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        string       name;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] one_shot(input int n, input int k);
        return (k >= n) ? 32'd0 : 32'(n - k);
    endfunction

    function automatic logic [31:0] auto_cnt(input int n, input int k);
        return 32'(n - (k % n));
    endfunction

    // Called at a negedge; returns at the negedge after the ready pulse.
    // c_e is the edge on which the access completed (write commit edge).
    task automatic bus_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                            output int c_e);
        int   s_e;
        bit   got;
        exp_t e;
        strobe = 1'b1;
        rw     = w;
        addr   = {24'h0, a};
        wdata  = d;
        @(negedge clk);
        s_e    = cyc;
        strobe = 1'b0;
        got    = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
        end
        c_e = cyc;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_timeout addr %h: no data_ready within 50 cycles", a);
            if (!w && sb.size() > 0) e = sb.pop_front();
        end else begin
            check("ready_latency", 32'(c_e - s_e), 32'(LAT + 2));
            if (!w) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got %h, expected an entry", rdata);
                end else begin
                    e = sb.pop_front();
                    check(e.name, rdata, e.val);
                end
            end
            @(negedge clk);
            check("ready_pulse_width", 32'(ready), 32'd0);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, output int c_e);
        bus_xfer(1'b1, a, d, c_e);
    endtask

    task automatic rd(input logic [7:0] a, input string name, input logic [31:0] expv);
        exp_t e;
        int   c_e;
        e.name = name;
        e.val  = expv;
        sb.push_back(e);
        bus_xfer(1'b0, a, 32'h0, c_e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int c, ca, ce, cl, cx, cw, cp, v, t, hi;

    initial begin
        rst_n  = 1'b0;
        strobe = 1'b0;
        rw     = 1'b0;
        addr   = '0;
        be     = '1;
        wdata  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Static register behaviour (EN stays 0 throughout)
        tbl.push_back('{1'b0, 8'h00, 32'h0,        "rst_ctrl"});
        tbl.push_back('{1'b0, 8'h04, 32'h0,        "rst_load"});
        tbl.push_back('{1'b0, 8'h08, 32'h0,        "rst_count"});
        tbl.push_back('{1'b0, 8'h0C, 32'h0,        "rst_status"});
        tbl.push_back('{1'b0, 8'h40, 32'hdeadbeef, "unmapped_40_rd"});
        tbl.push_back('{1'b0, 8'h10, OFF10_RST,    "offset_10_rd"});
        tbl.push_back('{1'b1, 8'h04, 32'h1234,     ""});
        tbl.push_back('{1'b0, 8'h04, 32'h1234,     "load_readback"});
        tbl.push_back('{1'b0, 8'h08, 32'h1234,     "load_copies_count"});
        tbl.push_back('{1'b1, 8'h08, 32'h55,       ""});
        tbl.push_back('{1'b0, 8'h08, 32'h1234,     "count_read_only"});
        tbl.push_back('{1'b1, 8'h00, 32'hFFFFFFFA, ""});
        tbl.push_back('{1'b0, 8'h00, 32'h2,        "ctrl_bits_only"});
        tbl.push_back('{1'b1, 8'h40, 32'hFFFFFFFF, ""});
        tbl.push_back('{1'b0, 8'h00, 32'h2,        "unmapped_wr_ctrl"});
        tbl.push_back('{1'b0, 8'h04, 32'h1234,     "unmapped_wr_load"});
        tbl.push_back('{1'b0, 8'h08, 32'h1234,     "unmapped_wr_count"});
        tbl.push_back('{1'b0, 8'h0C, 32'h0,        "unmapped_wr_status"});
        tbl.push_back('{1'b1, 8'h00, 32'h0,        ""});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d, c);
            else          rd(tbl[i].a, tbl[i].name, tbl[i].d);
        end

        // One-shot: LOAD=5, CTRL=EN|IE; EXP at commit+5, irq at commit+6
        wr(8'h04, 32'd5, c);
        wr(8'h00, 32'h5, ca);
        for (int i = 0; i < 8; i++) begin
            t = cyc;
            check("oneshot_irq_timing", 32'(irq), 32'(t - ca >= 6));
            @(negedge clk);
        end
        rd(8'h08, "oneshot_count_hold", 32'd0);
        rd(8'h0C, "oneshot_exp_set", 32'd1);
        wr(8'h0C, 32'h0, c);
        rd(8'h0C, "status_w0_no_effect", 32'd1);

        // Intermediate counts of a running one-shot
        wr(8'h04, 32'd20, cl);
        v = cyc + 1 + LAT;
        rd(8'h08, "oneshot_count_a", one_shot(20, v - cl));
        v = cyc + 1 + LAT;
        rd(8'h08, "oneshot_count_b", one_shot(20, v - cl));
        repeat (10) @(negedge clk);
        wr(8'h0C, 32'h1, c);
        check("w1c_irq_low", 32'(irq), 32'd0);
        rd(8'h0C, "w1c_clears_exp", 32'd0);

        // Auto-reload: LOAD=3, CTRL=EN|AUTO|IE
        wr(8'h00, 32'h0, c);
        wr(8'h04, 32'd3, c);
        wr(8'h00, 32'h7, ca);
        for (int i = 0; i < 3; i++) begin
            v = cyc + 1 + LAT;
            rd(8'h08, "auto_count_phase", auto_cnt(3, v - ca));
        end
        check("auto_irq_high", 32'(irq), 32'd1);
        rd(8'h0C, "auto_exp_set", 32'd1);

        // W1C between expiries: irq drops for two cycles then returns
        for (int i = 0; i < 3 && ((cyc + LAT + 3 - ca) % 3 != 1); i++) @(negedge clk);
        wr(8'h0C, 32'h1, cw);
        check("w1c_gap_irq_p1", 32'(irq), 32'd0);
        @(negedge clk);
        check("w1c_gap_irq_p2", 32'(irq), 32'd0);
        @(negedge clk);
        check("w1c_gap_irq_p3", 32'(irq), 32'd1);

        // W1C on the expiry edge: set wins, irq never drops
        for (int i = 0; i < 3 && ((cyc + LAT + 3 - ca) % 3 != 0); i++) @(negedge clk);
        wr(8'h0C, 32'h1, cw);
        check("w1c_collide_irq_p1", 32'(irq), 32'd1);
        @(negedge clk);
        check("w1c_collide_irq_p2", 32'(irq), 32'd1);

        // LOAD write on the expiry edge: new LOAD wins, no EXP
        wr(8'h00, 32'h0, c);
        wr(8'h0C, 32'h1, c);
        wr(8'h04, 32'd7, c);
        wr(8'h00, 32'h1, ce);
        for (int i = 0; i < 20 && (cyc + LAT + 3 < ce + 7); i++) @(negedge clk);
        wr(8'h04, 32'd50, cl);
        rd(8'h0C, "load_collide_no_exp", 32'd0);
        v = cyc + 1 + LAT;
        rd(8'h08, "load_collide_count", one_shot(50, v - cl));

        // Clearing EN: the commit-edge decrement still happens, then COUNT holds
        wr(8'h00, 32'h0, cx);
        repeat (5) @(negedge clk);
        rd(8'h08, "en_off_count_hold", one_shot(50, cx - cl));

        // LOAD=0 with EN=1 never expires
        wr(8'h04, 32'd0, c);
        wr(8'h00, 32'h5, c);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (irq) hi++;
        end
        check("load0_irq_cycles", 32'(hi), 32'd0);
        rd(8'h0C, "load0_no_exp", 32'd0);
        rd(8'h08, "load0_count", 32'd0);

`ifdef DEV_TIMER_PRESCALE_EN
        // PRESC=3, LOAD=2: decrement every 4 cycles, EXP at commit+8
        wr(8'h00, 32'h0, c);
        wr(8'h10, 32'd3, c);
        wr(8'h04, 32'd2, c);
        wr(8'h00, 32'h5, cp);
        for (int i = 0; i < 10; i++) begin
            t = cyc;
            check("presc_irq_timing", 32'(irq), 32'(t - cp >= 9));
            @(negedge clk);
        end
        rd(8'h10, "presc_readback", 32'd3);
        rd(8'h08, "presc_count_done", 32'd0);
`endif

        // Reset in the middle of a write: no commit, bus back to IDLE
        strobe = 1'b1;
        rw     = 1'b1;
        addr   = 32'h4;
        wdata  = 32'h99;
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_ready", 32'(ready), 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            if (ready) hi++;
        end
        check("rst_mid_no_ready", 32'(hi), 32'd0);
        rd(8'h04, "rst_mid_no_commit", 32'd0);
        rd(8'h08, "rst_mid_count", 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
